// File: rtl/sram_bank_ctrl.sv
// Multi-bank SRAM back-end: independent write/read request ports, per-bank
// round-robin arbitration on conflicts, range checking and a 2-entry read response buffer.
module sram_bank_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int WORD_DEPTH = 512,
    parameter int BANK_NUM   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int INTERLEAVE = 0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    output logic                    wresp_valid_o,
    output logic                    wresp_err_o,
    input  logic                    rd_valid_i,
    output logic                    rd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    rerr_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int BOFF   = $clog2(STRB_W);
    localparam int WL     = $clog2(WORD_DEPTH);
    localparam int BL     = $clog2(BANK_NUM);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(BANK_NUM * WORD_DEPTH * STRB_W);

    typedef enum logic {
        PORT_WR = 1'b0,
        PORT_RD = 1'b1
    } port_e;

    logic            wr_oor, rd_oor;
    logic [BL-1:0]   wr_bank, rd_bank;
    logic [WL-1:0]   wr_word, rd_word;
    logic            conflict, wr_lose, rd_lose, rd_space;
    logic            wr_grant, rd_grant;
    port_e           winner;

    logic [BANK_NUM-1:0]   bank_en, bank_wen;
    logic [STRB_W-1:0]     bank_bm    [BANK_NUM];
    logic [WL-1:0]         bank_addr  [BANK_NUM];
    logic [DATA_WIDTH-1:0] bank_wdat  [BANK_NUM];
    logic [DATA_WIDTH-1:0] bank_rdata [BANK_NUM];

    port_e                 last_q, last_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [BL-1:0]         rd_bank_q, rd_bank_d;
    logic                  rd_err_q, rd_err_d;
    logic [DATA_WIDTH-1:0] fifo_dat_q [2];
    logic [DATA_WIDTH-1:0] fifo_dat_d [2];
    logic [1:0]            fifo_err_q, fifo_err_d;
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  wresp_valid_q, wresp_valid_d;
    logic                  wresp_err_q, wresp_err_d;

    logic                  fifo_empty, pop, fifo_pop, push;
    logic [DATA_WIDTH-1:0] inflight_dat;

    assign wr_oor  = {1'b0, wr_addr_i} >= ADDR_LIMIT;
    assign rd_oor  = {1'b0, rd_addr_i} >= ADDR_LIMIT;
    assign wr_bank = (INTERLEAVE != 0) ? wr_addr_i[BOFF +: BL] : wr_addr_i[BOFF+WL +: BL];
    assign rd_bank = (INTERLEAVE != 0) ? rd_addr_i[BOFF +: BL] : rd_addr_i[BOFF+WL +: BL];
    assign wr_word = (INTERLEAVE != 0) ? wr_addr_i[BOFF+BL +: WL] : wr_addr_i[BOFF +: WL];
    assign rd_word = (INTERLEAVE != 0) ? rd_addr_i[BOFF+BL +: WL] : rd_addr_i[BOFF +: WL];

    // Out-of-range requests touch no bank, so they never take part in a conflict.
    assign conflict = wr_valid_i && rd_valid_i && !wr_oor && !rd_oor && (wr_bank == rd_bank);
    assign winner   = (last_q == PORT_WR) ? PORT_RD : PORT_WR;
    assign wr_lose  = conflict && (winner == PORT_RD);
    assign rd_lose  = conflict && (winner == PORT_WR);
    assign rd_space = (count_q + 2'(rd_inflight_q)) < 2'd2;

    assign wr_ready_o = !wr_lose;
    assign rd_ready_o = !rd_lose && rd_space;
    assign wr_grant   = wr_valid_i && wr_ready_o;
    assign rd_grant   = rd_valid_i && rd_ready_o;

    always_comb begin
        bank_en  = '0;
        bank_wen = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            bank_bm[b]   = '0;
            bank_addr[b] = '0;
            bank_wdat[b] = '0;
        end
        if (wr_grant && !wr_oor) begin
            bank_en[wr_bank]   = 1'b1;
            bank_wen[wr_bank]  = 1'b1;
            bank_bm[wr_bank]   = wr_strb_i;
            bank_addr[wr_bank] = wr_word;
            bank_wdat[wr_bank] = wr_dat_i;
        end
        if (rd_grant && !rd_oor) begin
            bank_en[rd_bank]   = 1'b1;
            bank_addr[rd_bank] = rd_word;
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [WORD_DEPTH];
        logic [DATA_WIDTH-1:0] rdata_q;

        always_ff @(posedge aclk) begin
            if (bank_en[b]) begin
                if (bank_wen[b]) begin
                    for (int i = 0; i < STRB_W; i++) begin
                        if (bank_bm[b][i]) begin
                            mem[bank_addr[b]][i*8 +: 8] <= bank_wdat[b][i*8 +: 8];
                        end
                    end
                end else begin
                    rdata_q <= mem[bank_addr[b]];
                end
            end
        end

        assign bank_rdata[b] = rdata_q;
    end

    // The in-flight read is presented directly when the buffer is empty, giving 1-cycle latency.
    assign inflight_dat = rd_err_q ? '0 : bank_rdata[rd_bank_q];
    assign fifo_empty   = (count_q == 2'd0);
    assign rvalid_o     = !fifo_empty || rd_inflight_q;
    assign rdata_o      = !fifo_empty ? fifo_dat_q[rd_ptr_q] : (rd_inflight_q ? inflight_dat : '0);
    assign rerr_o       = !fifo_empty ? fifo_err_q[rd_ptr_q] : (rd_inflight_q && rd_err_q);
    assign pop          = rvalid_o && rready_i;
    assign fifo_pop     = pop && !fifo_empty;
    assign push         = rd_inflight_q && !(fifo_empty && pop);

    assign wresp_valid_o = wresp_valid_q;
    assign wresp_err_o   = wresp_err_q;

    always_comb begin
        last_d        = conflict ? winner : last_q;
        wresp_valid_d = wr_grant;
        wresp_err_d   = wr_grant && wr_oor;
        rd_inflight_d = rd_grant;
        rd_bank_d     = rd_bank;
        rd_err_d      = rd_oor;
        fifo_dat_d    = fifo_dat_q;
        fifo_err_d    = fifo_err_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (push) begin
            fifo_dat_d[wr_ptr_q] = inflight_dat;
            fifo_err_d[wr_ptr_q] = rd_err_q;
            wr_ptr_d             = !wr_ptr_q;
        end
        if (fifo_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(fifo_pop);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            last_q        <= PORT_WR;
            rd_inflight_q <= 1'b0;
            rd_bank_q     <= '0;
            rd_err_q      <= 1'b0;
            fifo_dat_q    <= '{default: '0};
            fifo_err_q    <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= '0;
            wresp_valid_q <= 1'b0;
            wresp_err_q   <= 1'b0;
        end else begin
            last_q        <= last_d;
            rd_inflight_q <= rd_inflight_d;
            rd_bank_q     <= rd_bank_d;
            rd_err_q      <= rd_err_d;
            fifo_dat_q    <= fifo_dat_d;
            fifo_err_q    <= fifo_err_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wresp_valid_q <= wresp_valid_d;
            wresp_err_q   <= wresp_err_d;
        end
    end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl: block-mapped instance checked through a read response
// scoreboard plus directed checks, and a word-interleaved instance checked directly.
module tb_sram_bank_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;

    logic        wr_valid_i = 1'b0;
    logic        wr_ready_o;
    logic [31:0] wr_addr_i = '0;
    logic [31:0] wr_dat_i = '0;
    logic [3:0]  wr_strb_i = '0;
    logic        wresp_valid_o, wresp_err_o;
    logic        rd_valid_i = 1'b0;
    logic        rd_ready_o;
    logic [31:0] rd_addr_i = '0;
    logic        rvalid_o;
    logic        rready_i = 1'b1;
    logic [31:0] rdata_o;
    logic        rerr_o;

    logic        il_wr_valid = 1'b0;
    logic        il_wr_ready;
    logic [31:0] il_wr_addr = '0;
    logic [31:0] il_wr_dat = '0;
    logic        il_wresp_valid, il_wresp_err;
    logic        il_rd_valid = 1'b0;
    logic        il_rd_ready;
    logic [31:0] il_rd_addr = '0;
    logic        il_rvalid;
    logic [31:0] il_rdata;
    logic        il_rerr;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t        rsp_q[$];
    rsp_t        rsp_exp;
    logic [31:0] model [int unsigned];
    logic [31:0] cur;
    bit          wacc_prev = 1'b0;
    bit          wacc_err_prev = 1'b0;
    logic [31:0] rd_d;
    logic        rd_e;

    always #5 aclk = ~aclk;

    sram_bank_ctrl #(.DATA_WIDTH(32), .WORD_DEPTH(512), .BANK_NUM(4), .ADDR_WIDTH(32), .INTERLEAVE(0)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
        .wr_dat_i(wr_dat_i), .wr_strb_i(wr_strb_i),
        .wresp_valid_o(wresp_valid_o), .wresp_err_o(wresp_err_o),
        .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_addr_i(rd_addr_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rerr_o(rerr_o)
    );

    sram_bank_ctrl #(.DATA_WIDTH(32), .WORD_DEPTH(512), .BANK_NUM(4), .ADDR_WIDTH(32), .INTERLEAVE(1)) dut_il (
        .aclk(aclk), .aresetn(aresetn),
        .wr_valid_i(il_wr_valid), .wr_ready_o(il_wr_ready), .wr_addr_i(il_wr_addr),
        .wr_dat_i(il_wr_dat), .wr_strb_i(4'hF),
        .wresp_valid_o(il_wresp_valid), .wresp_err_o(il_wresp_err),
        .rd_valid_i(il_rd_valid), .rd_ready_o(il_rd_ready), .rd_addr_i(il_rd_addr),
        .rvalid_o(il_rvalid), .rready_i(1'b1), .rdata_o(il_rdata), .rerr_o(il_rerr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: record accepted requests, compare responses in order as they leave the DUT.
    always @(negedge aclk) begin
        if (!aresetn) begin
            rsp_q.delete();
            wacc_prev     = 1'b0;
            wacc_err_prev = 1'b0;
        end else begin
            if (wacc_prev) begin
                checkOutput("wresp_valid", 32'(wresp_valid_o), 32'd1);
                checkOutput("wresp_err", 32'(wresp_err_o), 32'(wacc_err_prev));
            end else if (wresp_valid_o) begin
                checkOutput("wresp_spurious", 32'(wresp_valid_o), 32'd0);
            end
            if (rvalid_o && rready_i) begin
                if (rsp_q.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'(rvalid_o), 32'd0);
                end else begin
                    rsp_exp = rsp_q.pop_front();
                    checkOutput("sb_rdata", rdata_o, rsp_exp.dat);
                    checkOutput("sb_rerr", 32'(rerr_o), 32'(rsp_exp.err));
                end
            end
            wacc_prev     = wr_valid_i && wr_ready_o;
            wacc_err_prev = wr_addr_i >= 32'h2000;
            if (wacc_prev && !wacc_err_prev) begin
                cur = model.exists(wr_addr_i >> 2) ? model[wr_addr_i >> 2] : 32'h0;
                for (int i = 0; i < 4; i++) begin
                    if (wr_strb_i[i]) cur[i*8 +: 8] = wr_dat_i[i*8 +: 8];
                end
                model[wr_addr_i >> 2] = cur;
            end
            if (rd_valid_i && rd_ready_o) begin
                if (rd_addr_i >= 32'h2000) begin
                    rsp_q.push_back('{err: 1'b1, dat: 32'h0});
                end else begin
                    rsp_q.push_back('{err: 1'b0, dat: model[rd_addr_i >> 2]});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Present a write and/or read and hold each until accepted, within a cycle budget.
    task automatic applyStimulus(input bit do_wr, input logic [31:0] wa, input logic [31:0] wd,
                                 input logic [3:0] ws, input bit do_rd, input logic [31:0] ra);
        int  cyc;
        bit  wacc, racc;
        wr_valid_i = do_wr;
        wr_addr_i  = wa;
        wr_dat_i   = wd;
        wr_strb_i  = ws;
        rd_valid_i = do_rd;
        rd_addr_i  = ra;
        cyc = 0;
        while ((wr_valid_i || rd_valid_i) && cyc < 20) begin
            @(negedge aclk);
            wacc = wr_valid_i && wr_ready_o;
            racc = rd_valid_i && rd_ready_o;
            @(posedge aclk);
            #1;
            if (wacc) wr_valid_i = 1'b0;
            if (racc) rd_valid_i = 1'b0;
            cyc++;
        end
        checkOutput("accept_timeout", 32'(wr_valid_i || rd_valid_i), 32'd0);
        wr_valid_i = 1'b0;
        rd_valid_i = 1'b0;
    endtask

    task automatic readWord(input logic [31:0] ra, output logic [31:0] d, output logic e);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, ra);
        @(negedge aclk);
        d = rdata_o;
        e = rerr_o;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_wr_ready"}, 32'(wr_ready_o), 32'd1);
        checkOutput({tag, "_rd_ready"}, 32'(rd_ready_o), 32'd1);
        checkOutput({tag, "_wresp_valid"}, 32'(wresp_valid_o), 32'd0);
        checkOutput({tag, "_wresp_err"}, 32'(wresp_err_o), 32'd0);
        checkOutput({tag, "_rvalid"}, 32'(rvalid_o), 32'd0);
        checkOutput({tag, "_rdata"}, rdata_o, 32'd0);
        checkOutput({tag, "_rerr"}, 32'(rerr_o), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checkResetValues("rst");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Preload a word, then reset so the arbiter starts fresh; contents must survive.
        applyStimulus(1'b1, 32'h10, 32'h1234_5678, 4'hF, 1'b0, '0);
        idle(2);
        aresetn = 1'b0;
        idle(1);
        aresetn = 1'b1;

        // Same-bank stream: read wins first, then grants alternate.
        wr_valid_i = 1'b1;
        wr_addr_i  = 32'h0;
        wr_strb_i  = 4'hF;
        rd_valid_i = 1'b1;
        rd_addr_i  = 32'h10;
        for (int k = 0; k < 4; k++) begin
            wr_dat_i = 32'hA000_0000 + 32'(k);
            @(negedge aclk);
            checkOutput($sformatf("conf%0d_wr_ready", k), 32'(wr_ready_o), 32'(k % 2));
            checkOutput($sformatf("conf%0d_rd_ready", k), 32'(rd_ready_o), 32'((k + 1) % 2));
            @(posedge aclk);
            #1;
        end
        wr_valid_i = 1'b0;
        rd_valid_i = 1'b0;
        idle(2);

        // Block mapping: 0x0804 lives in bank 1.
        wr_valid_i = 1'b1;
        wr_addr_i  = 32'h0804;
        wr_dat_i   = 32'hDEAD_BEEF;
        wr_strb_i  = 4'hF;
        @(negedge aclk);
        checkOutput("blk_wr_bank_en", 32'(dut.bank_en), 32'h2);
        @(posedge aclk);
        #1;
        wr_valid_i = 1'b0;
        rd_valid_i = 1'b1;
        rd_addr_i  = 32'h0804;
        @(negedge aclk);
        checkOutput("blk_rd_bank_en", 32'(dut.bank_en), 32'h2);
        @(posedge aclk);
        #1;
        rd_valid_i = 1'b0;
        @(negedge aclk);
        checkOutput("blk_rvalid_lat", 32'(rvalid_o), 32'd1);
        checkOutput("blk_rdata", rdata_o, 32'hDEAD_BEEF);
        idle(1);

        // Byte strobes, including an all-zero strobe that must modify nothing.
        applyStimulus(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 1'b0, '0);
        applyStimulus(1'b1, 32'h100, 32'h0000_00AA, 4'h1, 1'b0, '0);
        applyStimulus(1'b1, 32'h100, 32'h1234_5678, 4'h0, 1'b0, '0);
        readWord(32'h100, rd_d, rd_e);
        checkOutput("strb_partial", rd_d, 32'hFFFF_FFAA);
        idle(1);

        // Out of range: no bank enabled, error reported, memory untouched.
        rd_valid_i = 1'b1;
        rd_addr_i  = 32'h2000;
        @(negedge aclk);
        checkOutput("oor_rd_bank_en", 32'(dut.bank_en), 32'h0);
        @(posedge aclk);
        #1;
        rd_valid_i = 1'b0;
        @(negedge aclk);
        checkOutput("oor_rdata", rdata_o, 32'h0);
        checkOutput("oor_rerr", 32'(rerr_o), 32'd1);
        idle(1);
        applyStimulus(1'b1, 32'h2000, 32'h5555_5555, 4'hF, 1'b0, '0);
        readWord(32'h0, rd_d, rd_e);
        checkOutput("oor_wr_no_alias", rd_d, 32'hA000_0003);
        idle(1);

        // Back-pressure: two reads fill the buffer, the third stalls until a pop.
        applyStimulus(1'b1, 32'h200, 32'h0000_0200, 4'hF, 1'b0, '0);
        applyStimulus(1'b1, 32'h204, 32'h0000_0204, 4'hF, 1'b0, '0);
        applyStimulus(1'b1, 32'h208, 32'h0000_0208, 4'hF, 1'b0, '0);
        idle(1);
        rready_i   = 1'b0;
        rd_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rd_addr_i = 32'h200 + 32'(4 * (k < 2 ? k : 2));
            @(negedge aclk);
            checkOutput($sformatf("bp%0d_rd_ready", k), 32'(rd_ready_o), 32'(k < 2));
            @(posedge aclk);
            #1;
        end
        checkOutput("bp_hold_rdata", rdata_o, 32'h0000_0200);
        rready_i = 1'b1;
        @(negedge aclk);
        checkOutput("bp_pop_rd_ready", 32'(rd_ready_o), 32'd0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        checkOutput("bp_release_rd_ready", 32'(rd_ready_o), 32'd1);
        @(posedge aclk);
        #1;
        rd_valid_i = 1'b0;
        idle(4);
        checkOutput("bp_drain", 32'(rsp_q.size()), 32'd0);

        // Reset during a stall discards buffered responses.
        rready_i   = 1'b0;
        rd_valid_i = 1'b1;
        rd_addr_i  = 32'h204;
        idle(4);
        checkOutput("stall_rd_ready", 32'(rd_ready_o), 32'd0);
        rd_valid_i = 1'b0;
        aresetn    = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checkResetValues("rst2");
        rready_i = 1'b1;
        idle(3);
        checkOutput("rst2_no_rvalid", 32'(rvalid_o), 32'd0);

        // Word-interleaved instance: consecutive words land in consecutive banks.
        for (int i = 0; i < 4; i++) begin
            il_wr_valid = 1'b1;
            il_wr_addr  = 32'(4 * i);
            il_wr_dat   = 32'h11 * 32'(i + 1);
            @(negedge aclk);
            checkOutput($sformatf("il_wr%0d_bank_en", i), 32'(dut_il.bank_en), 32'(1 << i));
            checkOutput($sformatf("il_wr%0d_ready", i), 32'(il_wr_ready), 32'd1);
            @(posedge aclk);
            #1;
            il_wr_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            il_rd_valid = 1'b1;
            il_rd_addr  = 32'(4 * i);
            @(negedge aclk);
            checkOutput($sformatf("il_rd%0d_bank_en", i), 32'(dut_il.bank_en), 32'(1 << i));
            @(posedge aclk);
            #1;
            il_rd_valid = 1'b0;
            @(negedge aclk);
            checkOutput($sformatf("il_rd%0d_rvalid", i), 32'(il_rvalid), 32'd1);
            checkOutput($sformatf("il_rd%0d_rdata", i), il_rdata, 32'h11 * 32'(i + 1));
            @(posedge aclk);
            #1;
        end

        idle(3);
        checkOutput("sb_drain", 32'(rsp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
